// File: rtl/ifu_fetch_queue_if.sv
// Fetch request/response bus between the instruction fetch queue and the AXI-style read bridge.
interface ifu_fetch_queue_if #(
  parameter int unsigned CPU_WIDTH = 64
);
  logic                 o_req_valid;
  logic [CPU_WIDTH-1:0] o_req_addr;
  logic [1:0]           o_req_size;
  logic                 i_req_ready;
  logic                 i_rsp_valid;
  logic [CPU_WIDTH-1:0] i_rsp_data;
  logic [1:0]           i_rsp_resp;

  modport master (
    output o_req_valid, o_req_addr, o_req_size,
    input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_resp
  );

  modport slave (
    input  o_req_valid, o_req_addr, o_req_size,
    output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_resp
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: sequential PC generation, single outstanding read, DEPTH-entry
// instruction FIFO toward decode, redirect flush with stale-response dropping.
module ifu_fetch_queue #(
  parameter int unsigned          CPU_WIDTH = 64,
  parameter int unsigned          INS_WIDTH = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [CPU_WIDTH-1:0] PC_START  = 'h8000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_redirect,
  input  logic [CPU_WIDTH-1:0]     i_redirect_pc,
  input  logic                     i_stall,
  ifu_fetch_queue_if.master        bus,
  output logic                     o_if_id_valid,
  input  logic                     i_id_ready,
  output logic [CPU_WIDTH-1:0]     o_pc,
  output logic [INS_WIDTH-1:0]     o_ins,
  output logic                     o_fault,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CPU_WIDTH-1:0] PC_STEP = CPU_WIDTH'(4);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t               state, state_n;
  logic [CPU_WIDTH-1:0] fetch_pc, fetch_pc_n;
  logic [CPU_WIDTH-1:0] req_addr, req_addr_n;
  logic                 drop_pending, drop_pending_n;
  logic                 push, pop;

  logic [CPU_WIDTH-1:0] pc_mem    [DEPTH];
  logic [INS_WIDTH-1:0] ins_mem   [DEPTH];
  logic                 fault_mem [DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;

  logic                 rsp_fault;
  logic [INS_WIDTH-1:0] rsp_ins;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      fetch_pc     <= PC_START;
      req_addr     <= '0;
      drop_pending <= 1'b0;
    end else begin
      state        <= state_n;
      fetch_pc     <= fetch_pc_n;
      req_addr     <= req_addr_n;
      drop_pending <= drop_pending_n;
    end
  end

  // A redirect while the request is still waiting for ready cannot cancel it (the address
  // must stay stable), so it is remembered and the transaction is steered into DROP.
  always_comb begin
    state_n        = state;
    fetch_pc_n     = fetch_pc;
    req_addr_n     = req_addr;
    drop_pending_n = drop_pending;
    push           = 1'b0;
    case (state)
      IDLE: begin
        if (!i_stall && !i_redirect && (count < CNT_MAX)) begin
          state_n    = REQ;
          req_addr_n = fetch_pc;
        end
      end
      REQ: begin
        if (bus.i_req_ready) begin
          drop_pending_n = 1'b0;
          if (drop_pending || i_redirect) begin
            state_n = DROP;
          end else begin
            state_n    = WAIT;
            fetch_pc_n = fetch_pc + PC_STEP;
          end
        end else if (i_redirect) begin
          drop_pending_n = 1'b1;
        end
      end
      WAIT: begin
        if (bus.i_rsp_valid) begin
          state_n = IDLE;
          push    = !i_redirect;
        end else if (i_redirect) begin
          state_n = DROP;
        end
      end
      DROP: begin
        if (bus.i_rsp_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (i_redirect) fetch_pc_n = i_redirect_pc;
  end

  assign bus.o_req_valid = (state == REQ);
  assign bus.o_req_addr  = req_addr;
  assign bus.o_req_size  = 2'b10;

  assign rsp_fault = (bus.i_rsp_resp != 2'b00);
  assign rsp_ins   = rsp_fault   ? '0 :
                     req_addr[2] ? bus.i_rsp_data[2*INS_WIDTH-1:INS_WIDTH] :
                                   bus.i_rsp_data[INS_WIDTH-1:0];

  assign pop = (count != '0) && i_id_ready && !i_redirect;

  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= req_addr;
      ins_mem[wr_ptr]   <= rsp_ins;
      fault_mem[wr_ptr] <= rsp_fault;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign o_count       = count;
  assign o_if_id_valid = (count != '0);
  assign o_pc          = o_if_id_valid ? pc_mem[rd_ptr]    : '0;
  assign o_ins         = o_if_id_valid ? ins_mem[rd_ptr]   : '0;
  assign o_fault       = o_if_id_valid ? fault_mem[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Self-checking bench for ifu_fetch_queue: directed vector table, corner-case sequences,
// and randomized traffic against a transaction-level queue model.
module tb_ifu_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] PC0   = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        id_ready = 1'b0;
  logic        ifv;
  logic [63:0] pc;
  logic [31:0] ins;
  logic        fault;
  logic [2:0]  count;

  ifu_fetch_queue_if #(.CPU_WIDTH(64)) bus ();

  ifu_fetch_queue #(
    .CPU_WIDTH(64),
    .INS_WIDTH(32),
    .DEPTH(DEPTH),
    .PC_START(PC0)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_redirect(redirect),
    .i_redirect_pc(redirect_pc),
    .i_stall(stall),
    .bus(bus),
    .o_if_id_valid(ifv),
    .i_id_ready(id_ready),
    .o_pc(pc),
    .o_ins(ins),
    .o_fault(fault),
    .o_count(count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Reference model: expected FIFO contents plus the one in-flight transaction.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        fault;
  } ent_t;

  ent_t        mq[$];
  logic        m_busy, m_acc, m_stale;
  logic [63:0] m_addr, m_pc;
  logic [63:0] hs_log[$];
  logic [63:0] pop_log[$];

  // Bridge model driving the response side.
  bit          b_out;
  int unsigned b_cnt;
  int unsigned ready_pct = 100, lat_min = 1, lat_max = 1, fault_pct = 0;

  function automatic logic [63:0] log_at(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic tick();
    ent_t        e;
    logic        rsp, rdy, push;
    logic [63:0] data;
    logic [1:0]  resp;
    int unsigned sz;
    sz = mq.size();
    check("count", 64'(count), 64'(sz));
    check("if_id_valid", 64'(ifv), 64'(sz != 0));
    if (sz != 0) begin
      check("head_pc", pc, mq[0].pc);
      check("head_ins", 64'(ins), 64'(mq[0].ins));
      check("head_fault", 64'(fault), 64'(mq[0].fault));
    end else begin
      check("empty_head", {pc[62:0], fault} | 64'(ins), 64'h0);
    end
    check("req_valid", 64'(bus.o_req_valid), 64'(m_busy && !m_acc));
    if (m_busy && !m_acc) begin
      check("req_addr", bus.o_req_addr, m_addr);
      check("req_size", 64'(bus.o_req_size), 64'd2);
    end

    rsp  = b_out && (b_cnt == 0);
    rdy  = ($urandom_range(99) < ready_pct);
    data = {$urandom, $urandom};
    resp = ($urandom_range(99) < fault_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
    bus.i_req_ready = rdy;
    bus.i_rsp_valid = rsp;
    bus.i_rsp_data  = data;
    bus.i_rsp_resp  = resp;

    if (bus.o_req_valid && rdy) hs_log.push_back(bus.o_req_addr);
    if (ifv && id_ready && !redirect) pop_log.push_back(pc);

    push = 1'b0;
    if (m_busy) begin
      if (redirect) m_stale = 1'b1;
      if (!m_acc && rdy) begin
        m_acc = 1'b1;
        if (!m_stale) m_pc = m_pc + 64'd4;
      end else if (m_acc && rsp) begin
        m_busy = 1'b0;
        push   = !m_stale;
      end
    end else if (!stall && !redirect && sz < DEPTH) begin
      m_busy  = 1'b1;
      m_acc   = 1'b0;
      m_stale = 1'b0;
      m_addr  = m_pc;
    end
    e.pc    = m_addr;
    e.fault = (resp != 2'b00);
    e.ins   = e.fault ? 32'h0 : (m_addr[2] ? data[63:32] : data[31:0]);
    if (redirect) begin
      m_pc = redirect_pc;
      mq.delete();
    end else begin
      if (sz != 0 && id_ready) void'(mq.pop_front());
      if (push) mq.push_back(e);
    end

    if (rsp) b_out = 1'b0;
    else if (b_out && b_cnt != 0) b_cnt--;
    if (bus.o_req_valid && rdy) begin
      b_out = 1'b1;
      b_cnt = $urandom_range(lat_max, lat_min) - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    id_ready = 1'b0;
    bus.i_req_ready = 1'b0;
    bus.i_rsp_valid = 1'b0;
    bus.i_rsp_data  = '0;
    bus.i_rsp_resp  = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 64'(count), 64'h0);
    check("reset_req_valid", 64'(bus.o_req_valid), 64'h0);
    check("reset_if_id_valid", 64'(ifv), 64'h0);
    mq.delete();
    hs_log.delete();
    pop_log.delete();
    m_busy = 1'b0; m_acc = 1'b0; m_stale = 1'b0;
    m_addr = '0; m_pc = PC0;
    b_out = 1'b0; b_cnt = 0;
    ready_pct = 100; lat_min = 1; lat_max = 1; fault_pct = 0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        stall, ready, rsp_v;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        idr;
    logic        e_rv;
    logic [63:0] e_addr;
    logic        e_ifv;
    logic [2:0]  e_cnt;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    logic        e_fault;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // stall ready rsp data resp idr | req_valid addr ifv cnt pc ins fault
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 64'h0, 1'b0, 3'd0, 64'h0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 3'd0, 64'h0, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 64'hBBBB0000_AAAA0000, 2'b00, 1'b1, 1'b0, 64'h0, 1'b0, 3'd0, 64'h0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 64'h0, 1'b1, 3'd1, 64'h8000_0000, 32'hAAAA0000, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 3'd0, 64'h0, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 64'hBBBB0004_AAAA0004, 2'b10, 1'b1, 1'b0, 64'h0, 1'b0, 3'd0, 64'h0, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 64'h0, 1'b1, 3'd1, 64'h8000_0004, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 1'b1, 1'b1, 64'h8000_0008, 1'b0, 3'd0, 64'h0, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 64'hBBBB0008_AAAA0008, 2'b00, 1'b1, 1'b0, 64'h0, 1'b0, 3'd0, 64'h0, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 64'h0, 1'b1, 3'd1, 64'h8000_0008, 32'hAAAA0008, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 64'h0, 1'b0, 3'd0, 64'h0, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b1, 1'b0, 64'h0, 1'b0, 3'd0, 64'h0, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 64'h0, 2'b00, 1'b1, 1'b1, 64'h8000_000C, 1'b0, 3'd0, 64'h0, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 64'hBBBB000C_AAAA000C, 2'b00, 1'b0, 1'b0, 64'h0, 1'b0, 3'd0, 64'h0, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0, 64'h0, 1'b1, 3'd1, 64'h8000_000C, 32'hBBBB000C, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 1'b1, 64'h8000_0010, 1'b1, 3'd1, 64'h8000_000C, 32'hBBBB000C, 1'b0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("vec%0d_req_valid", i), 64'(bus.o_req_valid), 64'(vecs[i].e_rv));
      if (vecs[i].e_rv) check($sformatf("vec%0d_req_addr", i), bus.o_req_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_if_id_valid", i), 64'(ifv), 64'(vecs[i].e_ifv));
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("vec%0d_ins", i), 64'(ins), 64'(vecs[i].e_ins));
      check($sformatf("vec%0d_fault", i), 64'(fault), 64'(vecs[i].e_fault));
      stall           = vecs[i].stall;
      id_ready        = vecs[i].idr;
      bus.i_req_ready = vecs[i].ready;
      bus.i_rsp_valid = vecs[i].rsp_v;
      bus.i_rsp_data  = vecs[i].data;
      bus.i_rsp_resp  = vecs[i].resp;
      @(posedge clk);
      #1;
    end

    // Decode blocked: queue fills to DEPTH and fetch stops, then drains in order.
    do_reset();
    repeat (20) tick();
    check("full_req_issued", 64'(hs_log.size()), 64'(DEPTH));
    check("full_count", 64'(count), 64'(DEPTH));
    check("full_req_valid", 64'(bus.o_req_valid), 64'h0);
    id_ready = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 4; i++)
      check($sformatf("drain_pop%0d", i), log_at(pop_log, i), PC0 + 64'(4 * i));
    repeat (6) tick();
    check("resume_addr", log_at(hs_log, 4), 64'h8000_0010);

    // Redirect while waiting for a response.
    do_reset();
    repeat (4) tick();
    lat_min = 3; lat_max = 3;
    tick();
    check("pre_redirect_count", 64'(count), 64'h1);
    redirect = 1'b1; redirect_pc = 64'h8000_1000;
    tick();
    redirect = 1'b0;
    check("wait_redirect_flush", 64'(count), 64'h0);
    repeat (10) tick();
    check("wait_redirect_next_req", log_at(hs_log, 2), 64'h8000_1000);
    check("wait_redirect_head", pc, 64'h8000_1000);

    // Redirect while the request is held by a slow ready.
    do_reset();
    ready_pct = 0;
    tick();
    redirect = 1'b1; redirect_pc = 64'h8000_2000;
    tick();
    redirect = 1'b0;
    check("req_hold_valid", 64'(bus.o_req_valid), 64'h1);
    check("req_hold_addr1", bus.o_req_addr, PC0);
    tick();
    check("req_hold_addr2", bus.o_req_addr, PC0);
    tick();
    ready_pct = 100;
    repeat (8) tick();
    check("req_redirect_old", log_at(hs_log, 0), PC0);
    check("req_redirect_new", log_at(hs_log, 1), 64'h8000_2000);
    check("req_redirect_head", pc, 64'h8000_2000);

    // Stall only gates new requests; response push and decode pop carry on.
    do_reset();
    id_ready = 1'b1; lat_min = 2; lat_max = 2;
    repeat (2) tick();
    stall = 1'b1;
    repeat (2) tick();
    check("stall_push_count", 64'(count), 64'h1);
    tick();
    check("stall_pop_count", 64'(count), 64'h0);
    repeat (2) tick();
    check("stall_no_req", 64'(bus.o_req_valid), 64'h0);
    stall = 1'b0;
    tick();
    check("stall_release_req", 64'(bus.o_req_valid), 64'h1);
    check("stall_release_addr", bus.o_req_addr, 64'h8000_0004);

    // Randomized traffic including redirects near the top of the address space.
    do_reset();
    ready_pct = 60; lat_min = 1; lat_max = 4; fault_pct = 15;
    for (int i = 0; i < 4000; i++) begin
      stall    = ($urandom_range(99) < 20);
      id_ready = ($urandom_range(99) < 60);
      redirect = ($urandom_range(99) < 4);
      if ($urandom_range(3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      else redirect_pc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
      tick();
    end
    redirect = 1'b0;
    stall = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
